fetch_stage: RTL and testbench

Instruction-fetch stage of the RISC-V core: owns the program counter, issues single-outstanding requests to instruction memory over a request/grant/response handshake, and drives the IF/ID pipeline register. The IF/ID instruction word feeds the decode stage, including the immediate generator. The stage handles hazard-unit stalls and branch redirects from execute, with correct killing of in-flight fetches.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the fetch, decode and immediate-generation
// stages of the RISC-V core.
//   NOP_INSTR      : bubble word (addi x0,x0,0) placed in IF/ID on reset/flush
//   fetch_state_t  : fetch-stage controller states
//   OPC_*          : 7-bit major opcodes (instr[6:0]) used by decode / immgen
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // only right after reset
    S_REQ  = 2'd1,  // request driven to instruction memory
    S_WAIT = 2'd2,  // granted, response outstanding
    S_HOLD = 2'd3   // response arrived during a stall, parked
  } fetch_state_t;

  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, issues one outstanding
// request at a time to instruction memory and drives the IF/ID register.
//
// Ports:
//   clk, rst_n       : clock (rising edge), synchronous active-low reset
//   stall            : hold IF/ID, do not accept new words
//   redirect         : taken branch/jump, flush IF/ID, restart at redirect_pc
//   redirect_pc      : new fetch target (low two bits ignored)
//   imem_req/addr    : fetch request and word address
//   imem_gnt         : memory accepts the request this cycle
//   imem_rvalid/rdata: response (never in the grant cycle)
//   if_id_pc/instr/valid : IF/ID pipeline register
//   dbg_state        : current controller state, for observation only
//
// Memory handshake: a request transfers on any cycle where imem_req and
// imem_gnt are both high; imem_req/imem_addr stay stable until then unless a
// redirect moves the PC. Exactly one response (imem_rvalid) follows each
// transfer, at least one cycle later. No new request is made until it arrives.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  if_id_pc,
  output logic [31:0]  if_id_instr,
  output logic         if_id_valid,
  output fetch_state_t dbg_state
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         kill_q, kill_d;
  logic [31:0]  hold_q, hold_d;
  logic         req_q, req_d;
  logic [31:0]  if_id_pc_q, if_id_pc_d;
  logic [31:0]  if_id_instr_q, if_id_instr_d;
  logic         if_id_valid_q, if_id_valid_d;

  // Fetch targets are word aligned; the byte offset of redirect_pc is dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    hold_d        = hold_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
          // A grant coinciding with a redirect fetched the old path.
          kill_d  = redirect;
        end
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          kill_d = 1'b0;
          if (kill_q || redirect) begin
            state_d = S_REQ;
          end else if (stall) begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem_rdata;
            if_id_valid_d = 1'b1;
            pc_d          = pc_q + 32'd4;
            state_d       = S_REQ;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end

      S_HOLD: begin
        // pc_q still holds the address of the parked word.
        if (redirect) begin
          state_d = S_REQ;
        end else if (!stall) begin
          if_id_pc_d    = pc_q;
          if_id_instr_d = hold_q;
          if_id_valid_d = 1'b1;
          pc_d          = pc_q + 32'd4;
          state_d       = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Redirect overrides any PC advance and flushes IF/ID.
    if (redirect) begin
      pc_d          = {redirect_pc[31:2], 2'b00};
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end

    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      hold_q        <= NOP_INSTR;
      req_q         <= 1'b0;
      if_id_pc_q    <= 32'h0000_0000;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_q        <= kill_d;
      hold_q        <= hold_d;
      req_q         <= req_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: drives fetch_stage with a latency-randomised instruction
// memory, random stalls and redirects, and compares IF/ID writes and fetch
// addresses against a program-flow model (addresses advance by 4 from the
// last redirect target; a fetch is lost if a redirect occurs between its
// grant and the moment it would be written to IF/ID).
module tb_fetch_stage;
  import riscv_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         stall;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  logic [31:0]  if_id_pc;
  logic [31:0]  if_id_instr;
  logic         if_id_valid;
  fetch_state_t dbg_state;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- scoreboard state ----------------
  // entry = {edge index at which IF/ID must show it, pc, instr}
  logic [95:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // memory + program-flow model
  logic        outst, doomed, parked, flush_chk;
  int          lat;
  logic [31:0] out_addr, park_addr, park_data, model_pc;

  // stimulus knobs
  logic        force_gnt, arm_stall, tput_chk;
  int          min_lat, max_lat, p_stall, p_redir, stall_cnt, last_gnt;
  int          redir_mode;  // 0 none, 1 when fetch outstanding, 2 with a grant, 3 now
  logic [31:0] redir_tgt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc_cnt);
    end
  endtask

  task automatic push_accept(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] c;
    c = cyc_cnt + 1;
    exp_q.push_back({c, a, d});
    model_pc = a + 32'd4;
  endtask

  // ---------------- driver: one cycle, called at a falling edge ----------------
  task automatic drive_cycle();
    logic rv, g, s, r;
    logic [31:0] rp, rd;
    if (flush_chk) begin
      check("flush_valid", {31'd0, if_id_valid}, 32'd0);
      check("flush_instr", if_id_instr, NOP_INSTR);
      flush_chk = 1'b0;
    end
    rv = 1'b0;
    rd = $urandom;
    if (outst) begin
      if (lat == 0) begin
        rv = 1'b1;
        rd = mem_word(out_addr);
      end else begin
        lat--;
      end
    end
    g = 1'b0;
    if (imem_req) begin
      check("req_while_busy", {31'd0, outst | parked}, 32'd0);
      g = force_gnt || ($urandom_range(0, 99) < 60);
      if (g) begin
        check("grant_addr", imem_addr, model_pc);
        if (tput_chk) begin
          if (last_gnt >= 0) check("grant_spacing", cyc_cnt - last_gnt, 32'd2);
          last_gnt = cyc_cnt;
        end
      end
    end
    if (arm_stall && outst) begin
      stall_cnt = 5;
      arm_stall = 1'b0;
    end
    if (stall_cnt > 0) begin
      s = 1'b1;
      stall_cnt--;
    end else begin
      s = ($urandom_range(0, 99) < p_stall);
    end
    r  = ($urandom_range(0, 99) < p_redir);
    rp = $urandom;
    if ((redir_mode == 1 && outst) || (redir_mode == 2 && g) || redir_mode == 3) begin
      r = 1'b1;
      rp = redir_tgt;
      redir_mode = 0;
    end

    stall = s; redirect = r; redirect_pc = rp;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;

    // expected consequences of the coming edge
    if (r) begin
      model_pc = {rp[31:2], 2'b00};
      if (rv) begin
        outst = 1'b0;
        doomed = 1'b0;
      end else if (outst) begin
        doomed = 1'b1;
      end
      parked = 1'b0;
      flush_chk = 1'b1;
    end else if (rv) begin
      outst = 1'b0;
      if (doomed) doomed = 1'b0;
      else if (s) begin
        parked = 1'b1; park_addr = out_addr; park_data = rd;
      end else push_accept(out_addr, rd);
    end else if (parked && !s) begin
      parked = 1'b0;
      push_accept(park_addr, park_data);
    end
    if (g) begin
      outst = 1'b1;
      doomed = r;
      out_addr = imem_addr;
      lat = $urandom_range(max_lat, min_lat);
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive_cycle();
  endtask

  task automatic set_knobs(input logic fg, input int lmin, input int lmax,
                           input int ps, input int pr);
    force_gnt = fg; min_lat = lmin; max_lat = lmax; p_stall = ps; p_redir = pr;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_if_id_pc"}, if_id_pc, 32'h0);
    check({tag, "_if_id_instr"}, if_id_instr, NOP_INSTR);
    check({tag, "_if_id_valid"}, {31'd0, if_id_valid}, 32'd0);
  endtask

  task automatic model_reset();
    outst = 1'b0; doomed = 1'b0; parked = 1'b0; flush_chk = 1'b0;
    lat = 0; model_pc = 32'h0; stall_cnt = 0; arm_stall = 1'b0;
    redir_mode = 0; tput_chk = 1'b0; last_gnt = -1;
    out_addr = 32'h0; park_addr = 32'h0; park_data = 32'h0;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
  endtask

  // ---------------- monitor: pops on every new IF/ID write ----------------
  initial begin : monitor
    logic        prev_v;
    logic [31:0] prev_pc, prev_i;
    logic [95:0] e;
    logic [31:0] c;
    prev_v = 1'b0; prev_pc = 32'h0; prev_i = 32'h0;
    forever begin
      @(negedge clk);
      if (if_id_valid === 1'b1 &&
          (!prev_v || if_id_pc !== prev_pc || if_id_instr !== prev_i)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL if_id_unexpected: got pc=%h instr=%h expected no write (cycle %0d)",
                   if_id_pc, if_id_instr, cyc_cnt);
        end else begin
          e = exp_q.pop_front();
          c = cyc_cnt;
          checks++;
          if ({c, if_id_pc, if_id_instr} !== e) begin
            errors++;
            $display("FAIL if_id_write: got cyc=%0d pc=%h instr=%h expected cyc=%0d pc=%h instr=%h",
                     c, if_id_pc, if_id_instr, e[95:64], e[63:32], e[31:0]);
          end
        end
      end
      prev_v = if_id_valid; prev_pc = if_id_pc; prev_i = if_id_instr;
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int waited;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    set_knobs(1'b1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);

    // zero-wait streaming: one instruction every 2 cycles
    tput_chk = 1'b1;
    run(20);
    tput_chk = 1'b0;

    // stall for 5 cycles with a response in flight
    arm_stall = 1'b1;
    run(16);

    // redirect to 0x100 while the fetch is waiting on memory
    set_knobs(1'b1, 2, 2, 0, 0);
    redir_mode = 1; redir_tgt = 32'h0000_0100;
    run(16);
    check("redir_wait_fired", redir_mode, 32'd0);

    // redirect to 0x203 in the cycle the request is granted
    set_knobs(1'b1, 1, 1, 0, 0);
    redir_mode = 2; redir_tgt = 32'h0000_0203;
    run(16);
    check("redir_gnt_fired", redir_mode, 32'd0);

    // PC wrap at the top of the address space
    set_knobs(1'b1, 0, 0, 0, 0);
    redir_mode = 3; redir_tgt = 32'hFFFF_FFF8;
    run(12);

    // randomised traffic
    set_knobs(1'b0, 0, 3, 20, 4);
    run(2000);
    set_knobs(1'b0, 0, 3, 0, 0);
    run(20);

    // reset while a fetch is outstanding, then a stray response
    set_knobs(1'b1, 3, 3, 0, 0);
    waited = 0;
    while (!outst && waited < 50) begin
      drive_cycle();
      waited++;
    end
    check("outstanding_before_reset", {31'd0, outst}, 32'd1);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    model_reset();
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("stray_req", {31'd0, imem_req}, 32'd1);
    check("stray_addr", imem_addr, 32'h0);
    check("stray_valid", {31'd0, if_id_valid}, 32'd0);
    @(negedge clk);
    check("stray2_instr", if_id_instr, NOP_INSTR);
    check("stray2_valid", {31'd0, if_id_valid}, 32'd0);
    imem_rvalid = 1'b0;
    set_knobs(1'b1, 0, 1, 0, 0);
    run(20);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
